// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection scheduler: state encoding,
// active-low lamp patterns and default phase durations in ticks.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED2  = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  // {red,yellow,green}, 0 = lamp on
  localparam logic [2:0] LAMP_RED = 3'b011;
  localparam logic [2:0] LAMP_YEL = 3'b101;
  localparam logic [2:0] LAMP_GRN = 3'b110;

  localparam int DEF_GREEN_T  = 5;
  localparam int DEF_YELLOW_T = 2;
  localparam int DEF_ALLRED_T = 1;
  localparam int DEF_WALK_T   = 8;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-clk tick every TICK_DIV cycles, restarted by rst.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || tick) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/intersection_sched.sv
// Two-way traffic-light scheduler with optional pedestrian walk phase
// (enabled by defining INTERSECTION_PED_EN).
module intersection_sched
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int GREEN_T  = DEF_GREEN_T,
  parameter int YELLOW_T = DEF_YELLOW_T,
  parameter int ALLRED_T = DEF_ALLRED_T,
  parameter int WALK_T   = DEF_WALK_T
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  output logic [2:0] ns_leds,
  output logic [2:0] ew_leds,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [3:0] seconds_left,
  output logic [2:0] phase
);

  state_t     state, state_nxt;
  logic [3:0] secs, secs_nxt;
  logic       tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  function automatic logic [3:0] dur(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   dur = 4'(GREEN_T);
      NS_YELLOW, EW_YELLOW: dur = 4'(YELLOW_T);
      PED_WALK:             dur = 4'(WALK_T);
      default:              dur = 4'(ALLRED_T);
    endcase
  endfunction

`ifdef INTERSECTION_PED_EN
  logic ped_pending, pend_nxt, ack_nxt;
  dir_t next_dir, dir_nxt;
`endif

  always_comb begin
    state_nxt = state;
    secs_nxt  = secs;
`ifdef INTERSECTION_PED_EN
    pend_nxt  = ped_pending | (ped_req && (state != PED_WALK));
    dir_nxt   = next_dir;
    ack_nxt   = 1'b0;
`endif
    if (tick) begin
      if (secs != 4'd0) begin
        secs_nxt = secs - 4'd1;
      end else begin
        case (state)
          NS_GREEN:  state_nxt = NS_YELLOW;
          NS_YELLOW: state_nxt = ALL_RED1;
          ALL_RED1:  state_nxt = EW_GREEN;
          EW_GREEN:  state_nxt = EW_YELLOW;
          EW_YELLOW: state_nxt = ALL_RED2;
          default:   state_nxt = NS_GREEN;
        endcase
`ifdef INTERSECTION_PED_EN
        // A request latched this very cycle waits for the next all-red.
        if (state == PED_WALK) begin
          state_nxt = (next_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
        end else if ((state == ALL_RED1 || state == ALL_RED2) && ped_pending) begin
          dir_nxt   = (state == ALL_RED1) ? DIR_EW : DIR_NS;
          state_nxt = PED_WALK;
          pend_nxt  = 1'b0;
          ack_nxt   = 1'b1;
        end
`endif
        secs_nxt = dur(state_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALL_RED2;
      secs  <= 4'(ALLRED_T);
    end else begin
      state <= state_nxt;
      secs  <= secs_nxt;
    end
  end

`ifdef INTERSECTION_PED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pending <= 1'b0;
      next_dir    <= DIR_NS;
      ped_ack     <= 1'b0;
    end else begin
      ped_pending <= pend_nxt;
      next_dir    <= dir_nxt;
      ped_ack     <= ack_nxt;
    end
  end

  assign ped_walk = (state == PED_WALK);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_walk       = 1'b0;
  assign ped_ack        = 1'b0;
`endif

  always_comb begin
    ns_leds = LAMP_RED;
    ew_leds = LAMP_RED;
    case (state)
      NS_GREEN:  ns_leds = LAMP_GRN;
      NS_YELLOW: ns_leds = LAMP_YEL;
      EW_GREEN:  ew_leds = LAMP_GRN;
      EW_YELLOW: ew_leds = LAMP_YEL;
      default: ;
    endcase
  end

  assign seconds_left = secs;
  assign phase        = state;

endmodule
